exp_arbiter: RTL
================

// Module: exp_arbiter
// PURPOSE
//  Round-robin arbiter sharing one non-pipelined exp unit between NUM_REQ requesters (e.g. softmax lanes).
//  Accepts one request, issues it to exp, waits for the result (watchdog-protected) and returns it to the
//  granted requester. Exactly one transaction is in flight at a time; sits between layer lanes and exp.
// PARAMETERS
//  NUM_REQ     4    number of requester channels (>=2)
//  DATA_WIDTH  32   operand/result width (fixed point, passed through untouched)
//  TIMEOUT     256  max cycles waiting for exp_valid_out before abort (>=2)
//  localparam ID_WIDTH = clog2(NUM_REQ), TMR_WIDTH = clog2(TIMEOUT) (cnn1d_pkg::clog2)
// PORTS
//  clk              in   1                   clock, all logic on posedge
//  rst              in   1                   synchronous reset, active-low (rst==0 resets)
//  arb_valid_in     in   NUM_REQ             per-requester request valid
//  arb_ready_in     out  NUM_REQ             per-requester request accept (one-hot or zero)
//  arb_data_in      in   NUM_REQ*DATA_WIDTH  requester r operand at [r*DATA_WIDTH +: DATA_WIDTH]
//  arb_valid_out    out  NUM_REQ             per-requester result valid (one-hot or zero)
//  arb_ready_out    in   NUM_REQ             per-requester result accept
//  arb_data_out     out  DATA_WIDTH          shared result bus, meaningful where arb_valid_out set
//  arb_err_out      out  1                   qualifies arb_data_out: result is a timeout abort
//  exp_ready_in     in   1                   exp unit ready for operand
//  exp_valid_in     out  1                   operand valid to exp
//  exp_data_in      out  DATA_WIDTH          operand to exp
//  exp_ready_out    out  1                   arbiter ready for exp result
//  exp_valid_out    in   1                   exp result valid
//  exp_data_out     in   DATA_WIDTH          exp result
//  busy_out         out  1                   state != IDLE
//  timeout_cnt_out  out  8                   saturating count of aborted transactions
// BEHAVIOUR
//  Transfer on any interface = valid & ready at posedge. States IDLE, ISSUE, WAIT, RESPOND.
//  Reset (rst==0): state=IDLE, last_grant=NUM_REQ-1 (requester 0 highest priority), all valid/ready
//   outputs 0, data regs 0, arb_err_out 0, timer 0, timeout_cnt_out 0. Aborts any in-flight transaction;
//   the exp unit shares this reset.
//  IDLE: grant = first r with arb_valid_in[r], searching last_grant+1 .. wrapping mod NUM_REQ.
//   arb_ready_in[grant]=1 (comb) iff any valid; on transfer: latch operand and grant_id -> ISSUE.
//   exp_ready_out=1 in IDLE to drain stale post-timeout results (discarded).
//  ISSUE: exp_valid_in=1, exp_data_in=latched operand; on exp_ready_in -> WAIT, timer<=0.
//  WAIT: exp_ready_out=1; timer++ each cycle. exp_valid_out -> latch result, err=0, -> RESPOND.
//   timer==TIMEOUT-1 w/o exp_valid_out -> result=0, err=1, timeout_cnt_out++ (sat 255), -> RESPOND.
//   Simultaneous exp_valid_out and timer terminal: valid result wins, no error.
//  RESPOND: arb_valid_out[grant_id]=1, arb_data_out=result, arb_err_out=err; holds until
//   arb_ready_out[grant_id]; then last_grant<=grant_id -> IDLE. Other arb_ready_out bits ignored.
//  Requester must hold arb_valid_in/data until accepted; deasserting before accept drops it silently.
//  Min latency, request accept -> arb_valid_out: 3 cycles + exp latency (ISSUE,WAIT entry,RESPOND).
//  Back-to-back: next accept earliest the cycle after RESPOND completes (no overlap).
//  Fairness: a continuously-requesting channel waits at most NUM_REQ-1 transactions.
// TESTING
//  1 Reset: rst=0 for 2 cycles with all valids high -> all ready/valid outputs 0, busy_out=0.
//  2 Single req: r=2 sends 0x0100_0000 (1.0, FRACTION=24), exp model returns 0x02B7_E151 after 10
//    cycles -> arb_valid_out=4'b0100, data 0x02B7_E151, arb_err_out=0.
//  3 All 4 valid continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3; no grant to idle lane.
//  4 Exp model never returns, TIMEOUT=256 -> RESPOND 256 cycles after WAIT entry, data 0, err=1,
//    timeout_cnt_out=1; a stale exp_valid_out later in IDLE is drained and never reaches a requester.
//  5 Result backpressure: arb_ready_out[1] low 20 cycles -> arb_valid_out[1], data held stable,
//    arb_ready_in stays 0 for all lanes.
//  6 Reset asserted in WAIT -> next cycle IDLE, outputs at reset values, last_grant=NUM_REQ-1.

Source files
------------

// File: rtl/exp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : exp_arbiter
// Purpose  : Round-robin arbiter sharing one non-pipelined exp unit between
//            NUM_REQ requesters, with a watchdog abort on a missing result.
// Revision : 1.0 - initial release
// ============================================================================
module exp_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            arb_valid_in,
    output logic [NUM_REQ-1:0]            arb_ready_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] arb_data_in,
    output logic [NUM_REQ-1:0]            arb_valid_out,
    input  logic [NUM_REQ-1:0]            arb_ready_out,
    output logic [DATA_WIDTH-1:0]         arb_data_out,
    output logic                          arb_err_out,
    input  logic                          exp_ready_in,
    output logic                          exp_valid_in,
    output logic [DATA_WIDTH-1:0]         exp_data_in,
    output logic                          exp_ready_out,
    input  logic                          exp_valid_out,
    input  logic [DATA_WIDTH-1:0]         exp_data_out,
    output logic                          busy_out,
    output logic [7:0]                    timeout_cnt_out
);
    localparam int ID_WIDTH  = $clog2(NUM_REQ);
    localparam int WID       = ID_WIDTH + 1;
    localparam int TMR_WIDTH = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [ID_WIDTH-1:0]    r_last_grant, r_grant_id, w_grant;
    logic [DATA_WIDTH-1:0]  r_operand, r_result, w_operand;
    logic                   r_err;
    logic [TMR_WIDTH-1:0]   r_timer;
    logic [7:0]             r_timeout_cnt;
    logic [2*NUM_REQ-1:0]   w_dbl;
    logic [NUM_REQ-1:0]     w_rot;
    logic [WID-1:0]         w_shamt, w_off, w_sum;
    logic                   w_any, w_accept, w_resp_ack, w_timer_done;

    // Rotate the request vector so bit 0 is the lane just after the last grant.
    always_comb begin
        w_dbl   = {arb_valid_in, arb_valid_in};
        w_shamt = {1'b0, r_last_grant} + WID'(1);
        w_rot   = NUM_REQ'(w_dbl >> w_shamt);
        w_any   = 1'b0;
        w_off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_any = 1'b1;
                w_off = WID'(k);
            end
        end
        w_sum = w_shamt + w_off;
        if (w_sum >= WID'(NUM_REQ)) begin
            w_sum = w_sum - WID'(NUM_REQ);
        end
        w_grant   = w_sum[ID_WIDTH-1:0];
        w_operand = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_grant == ID_WIDTH'(j)) begin
                w_operand = arb_data_in[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        arb_ready_in  = '0;
        arb_valid_out = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            arb_ready_in[j]  = rst && (r_state == S_IDLE) && w_any && (w_grant == ID_WIDTH'(j));
            arb_valid_out[j] = rst && (r_state == S_RESPOND) && (r_grant_id == ID_WIDTH'(j));
        end
    end

    assign w_accept        = |(arb_ready_in & arb_valid_in);
    assign w_resp_ack      = |(arb_valid_out & arb_ready_out);
    assign w_timer_done    = (r_timer == TMR_WIDTH'(TIMEOUT - 1));
    assign arb_data_out    = r_result;
    assign arb_err_out     = r_err;
    assign exp_valid_in    = rst && (r_state == S_ISSUE);
    assign exp_data_in     = r_operand;
    // Also ready in IDLE so a late result from an aborted request is swallowed.
    assign exp_ready_out   = rst && ((r_state == S_IDLE) || (r_state == S_WAIT));
    assign busy_out        = (r_state != S_IDLE);
    assign timeout_cnt_out = r_timeout_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_accept)                      w_state_nxt = S_ISSUE;
            S_ISSUE:   if (exp_ready_in)                  w_state_nxt = S_WAIT;
            S_WAIT:    if (exp_valid_out || w_timer_done) w_state_nxt = S_RESPOND;
            S_RESPOND: if (w_resp_ack)                    w_state_nxt = S_IDLE;
            default:                                      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_grant  <= ID_WIDTH'(NUM_REQ - 1);
            r_grant_id    <= '0;
            r_operand     <= '0;
            r_result      <= '0;
            r_err         <= 1'b0;
            r_timer       <= '0;
            r_timeout_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_operand  <= w_operand;
                        r_grant_id <= w_grant;
                    end
                end
                S_ISSUE: begin
                    if (exp_ready_in) begin
                        r_timer <= '0;
                    end
                end
                S_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    // A result arriving on the terminal cycle still wins.
                    if (exp_valid_out) begin
                        r_result <= exp_data_out;
                        r_err    <= 1'b0;
                    end else if (w_timer_done) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                        if (r_timeout_cnt != 8'hFF) begin
                            r_timeout_cnt <= r_timeout_cnt + 8'd1;
                        end
                    end
                end
                S_RESPOND: begin
                    if (w_resp_ack) begin
                        r_last_grant <= r_grant_id;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire
